// File: rtl/floor_request_scheduler_pkg.sv
// Shared types, defaults and pending-set helpers
// for the floor request scheduler.
package floor_request_scheduler_pkg;

  localparam int FLOOR_W_DEF    = 4;
  localparam int MOVE_TICKS_DEF = 8;
  localparam int DOOR_TICKS_DEF = 4;

  // Helpers work on a widened set so any FLOOR_W up to 8 fits.
  localparam int PEND_MAX = 256;
  localparam int FIDX_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_e;

  typedef logic [PEND_MAX-1:0] pend_t;
  typedef logic [FIDX_W-1:0]   fidx_t;

  function automatic logic any_above(
    input pend_t p,
    input fidx_t f
  );
    pend_t s;
    s = p >> f;
    return |(s >> 1);
  endfunction

  function automatic logic any_below(
    input pend_t p,
    input fidx_t f
  );
    pend_t m;
    m = (pend_t'(1) << f) - pend_t'(1);
    return |(p & m);
  endfunction

endpackage

// File: rtl/floor_request_scheduler_tick_timer.sv
// Enable-gated tick counter; done fires on the
// enabled cycle that completes TICKS counts.
module tick_timer #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic done
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = en & ~restart & at_last;

endmodule

// File: rtl/floor_request_scheduler.sv
// SCAN elevator sequencer: request intake, sweep
// direction, timed floor steps and door dwell.
module floor_request_scheduler
  import floor_request_scheduler_pkg::*;
#(
  parameter int FLOOR_W    = FLOOR_W_DEF,
  parameter int MOVE_TICKS = MOVE_TICKS_DEF,
  parameter int DOOR_TICKS = DOOR_TICKS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [FLOOR_W-1:0]      floor_max,
  input  logic                    req_valid,
  input  logic [FLOOR_W-1:0]      req_floor,
  output logic                    req_accept,
  output logic                    req_reject,
  output logic [FLOOR_W-1:0]      cur_floor,
  output logic                    dir_up,
  output logic                    moving,
  output logic                    door_open,
  output logic                    arrive,
  output logic [(2**FLOOR_W)-1:0] pending
);

  localparam int NP = 2**FLOOR_W;

  typedef logic [FLOOR_W-1:0] floor_t;
  typedef logic [NP-1:0]      set_t;

  state_e state_q;
  state_e state_d;
  floor_t cur_q;
  floor_t cur_d;
  floor_t nxt;
  logic   dir_q;
  logic   dir_d;
  logic   clamp_q;
  logic   clamp_d;
  set_t   pend_q;
  set_t   pend_d;
  set_t   pend_n;
  set_t   legal;
  set_t   pm;
  logic   acc_q;
  logic   acc_d;
  logic   rej_q;
  logic   rej_d;
  logic   arr_q;
  logic   arr_d;

  logic req_ok;
  logic req_here;
  logic up_any;
  logic dn_any;
  logic ahead;
  logic behind;
  logic at_bound;
  logic mv_restart;
  logic mv_done;
  logic dr_restart;
  logic dr_done;

  always_comb begin
    legal = '0;
    for (int i = 0; i < NP; i++) begin
      legal[i] = (floor_t'(i) <= floor_max);
    end
  end

  assign req_ok   = req_valid & (req_floor <= floor_max);
  assign req_here = req_ok & (req_floor == cur_q)
                  & (state_q != MOVE);
  assign acc_d    = req_ok;
  assign rej_d    = req_valid & ~req_ok;

  assign pm     = pend_q & legal;
  assign up_any = any_above(pend_t'(pm), fidx_t'(cur_q));
  assign dn_any = any_below(pend_t'(pm), fidx_t'(cur_q));
  assign ahead  = dir_q ? up_any : dn_any;
  assign behind = dir_q ? dn_any : up_any;

  // A step past either end of the shaft turns the car around instead.
  assign at_bound = dir_q ? (cur_q >= floor_max)
                          : (cur_q == '0);
  assign nxt = dir_q ? cur_q + floor_t'(1)
                     : cur_q - floor_t'(1);

  assign mv_restart = (state_q != MOVE);
  assign dr_restart = (state_q != DOOR) | req_here;

  tick_timer #(
    .TICKS(MOVE_TICKS)
  ) u_move_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(mv_restart),
    .done   (mv_done)
  );

  tick_timer #(
    .TICKS(DOOR_TICKS)
  ) u_door_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(dr_restart),
    .done   (dr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dir_d   = dir_q;
    clamp_d = clamp_q;
    arr_d   = 1'b0;
    pend_n  = pend_q;
    if (req_ok && !req_here) begin
      pend_n[req_floor] = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (cur_q > floor_max) begin
          clamp_d = 1'b1;
          dir_d   = 1'b0;
          state_d = MOVE;
        end else if (req_here) begin
          state_d = DOOR;
        end else if (pm[cur_q]) begin
          pend_n[cur_q] = 1'b0;
          arr_d   = 1'b1;
          state_d = DOOR;
        end else if (ahead) begin
          state_d = MOVE;
        end else if (behind) begin
          dir_d   = ~dir_q;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (mv_done) begin
          if (at_bound) begin
            dir_d = ~dir_q;
            if (!clamp_q && (pend_n & legal) == '0) begin
              state_d = IDLE;
            end
          end else begin
            cur_d = nxt;
            if (pend_n[nxt] && nxt <= floor_max) begin
              pend_n[nxt] = 1'b0;
              arr_d   = 1'b1;
              clamp_d = 1'b0;
              state_d = DOOR;
            end else if (clamp_q && nxt <= floor_max) begin
              clamp_d = 1'b0;
              state_d = IDLE;
            end else if (!clamp_q
                         && (pend_n & legal) == '0) begin
              state_d = IDLE;
            end
          end
        end
      end
      DOOR: begin
        if (dr_done) begin
          if (ahead) begin
            state_d = MOVE;
          end else if (behind) begin
            dir_d   = ~dir_q;
            state_d = MOVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = pend_n & legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= '0;
      dir_q   <= 1'b1;
      clamp_q <= 1'b0;
      pend_q  <= '0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
      arr_q   <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      clamp_q <= clamp_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
      arr_q   <= arr_d;
    end
  end

  always_comb begin
    moving    = (state_q == MOVE);
    door_open = (state_q == DOOR);
  end

  assign req_accept = acc_q;
  assign req_reject = rej_q;
  assign cur_floor  = cur_q;
  assign dir_up     = dir_q;
  assign arrive     = arr_q;
  assign pending    = pend_q;

endmodule

// File: doc/floor_request_scheduler.md
# floor_request_scheduler

Sequencing controller for the car-position datapath: it collects floor requests into a pending set, chooses direction with a sweep (SCAN) policy, and steps the current floor one position at a time under a movement timer. It holds the doors open for a dwell period at each served floor. It sits between the request inputs and the capacity/floor-limit check, and applies the same limit rule to every requested target: a target above `floor_max` is refused.

## Interface
- `FLOOR_W`, 4, width of floor numbers; the pending set is 2^FLOOR_W bits.
- `MOVE_TICKS`, 8, enabled cycles per one-floor move (≥1).
- `DOOR_TICKS`, 4, enabled cycles the door stays open (≥1).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  timer tick enable; timers advance only when high. Requests are accepted regardless of `en`.
- `floor_max`  in  FLOOR_W  highest legal floor.
- `req_valid`  in  1  request strobe, one cycle per request.
- `req_floor`  in  FLOOR_W  requested floor.
- `req_accept`  out  1  one-cycle pulse: request entered the pending set.
- `req_reject`  out  1  one-cycle pulse: `req_floor > floor_max`.
- `cur_floor`  out  FLOOR_W  registered car position.
- `dir_up`  out  1  current sweep direction (1 = up).
- `moving`  out  1  high in MOVE.
- `door_open`  out  1  high in DOOR.
- `arrive`  out  1  one-cycle pulse when a pending floor is served.
- `pending`  out  2^FLOOR_W  registered pending set.

## Operation
- States: IDLE, MOVE, DOOR.
- **Reset values:** all outputs 0 except `dir_up = 1`. After reset the state is IDLE, `cur_floor = 0`, and both timers are cleared.
- **Request intake:**
  - If `req_floor > floor_max`, the request is rejected and `pending` is unchanged.
  - If the request targets `cur_floor` while in IDLE or DOOR, it is accepted but no pending bit is set. IDLE enters DOOR; DOOR restarts the dwell timer.
  - Any other legal request sets `pending[req_floor]`. A duplicate of an already-pending floor still pulses `req_accept`.
- **Direction choice** (evaluated in IDLE, and on leaving DOOR):
  - If any pending floor lies strictly ahead in `dir_up`, keep the direction and enter MOVE.
  - Otherwise, if any pending floor lies behind, toggle `dir_up` and enter MOVE.
  - Otherwise enter IDLE.
- **MOVE:**
  - The move timer counts enabled cycles. At count `MOVE_TICKS`, `cur_floor` steps ±1.
  - If the new floor is pending: clear its bit, pulse `arrive`, enter DOOR.
  - Otherwise, restart the move timer and stay in MOVE.
- **DOOR:** `door_open` is high for `DOOR_TICKS` enabled cycles, then direction choice runs.
- **Limit clamp:**
  - Every cycle, pending bits above `floor_max` are cleared.
  - If `cur_floor > floor_max` while in IDLE, an internal downward target is used: `dir_up = 0`, enter MOVE, and stop at `floor_max` without a door cycle or `arrive` pulse.
- **Boundaries:**
  - `cur_floor` never steps below 0 or above `floor_max`. If a step would cross a bound, reverse direction instead.
  - A request for the floor being arrived at, presented in the same cycle as the arrival, leaves that bit clear.

## Timing
- Request strobe in cycle N → `req_accept` or `req_reject` pulse, and the `pending` update, in cycle N+1.
- IDLE with a nonempty `pending` → `moving = 1` on the next cycle.
- One floor costs exactly `MOVE_TICKS` enabled cycles. With `en` held high, that is `MOVE_TICKS` clocks from MOVE entry to the `cur_floor` change.
- `arrive` and the `door_open` rise occur in the same cycle the `cur_floor` update becomes visible.
- The door dwell lasts exactly `DOOR_TICKS` enabled cycles.
- The next state after dwell is visible on the following cycle, with no idle bubble when more work is pending.
- `rst` asserted in any state, including mid-move or mid-dwell, forces reset values on the next edge. Pending requests are lost.

## Structure
- **Shared package:**
  - State enum {IDLE, MOVE, DOOR}.
  - Default constants for `FLOOR_W`, `MOVE_TICKS`, `DOOR_TICKS`.
  - Helper functions `any_above(pending, floor)` and `any_below(pending, floor)`.
- **Sub-module `tick_timer`:**
  - Parameterised terminal count, `en`-gated increment, `restart` input, `done` output.
  - Instantiated twice: one move timer, one door timer.

## Test plan
- **Reset and single request:** reset, `floor_max = 9`, request 3 with `en` high → `req_accept` next cycle; `cur_floor` 0→1→2→3 at 8-cycle spacing; `arrive` on reaching 3; `door_open` for 4 cycles; then IDLE.
- **Sweep order:** at floor 0, request 5, 2, 7 back to back → service order 2, 5, 7; `dir_up` stays 1 throughout.
- **Reversal:** at floor 5 moving up with pending {7, 1} → stop at 7, toggle `dir_up` to 0, then serve 1.
- **Limit reject and clamp:**
  - `floor_max = 4`, request 6 → `req_reject` and `pending` unchanged.
  - With the car idle at 8, lower `floor_max` to 4 → car descends to 4 with no `arrive`.
- **Same-floor and gating:**
  - Request `cur_floor` while IDLE → door opens the next cycle with no move.
  - `en` held low for 20 cycles mid-move → `cur_floor` frozen; the move resumes with the remaining ticks.
- **Reset mid-operation:** assert `rst` during DOOR with `pending = {2, 6}` → next cycle all outputs at reset values and `pending = 0`.
